// File: rtl/k16_panel_pkg.sv
// Shared constants, FSM encodings and slot/nibble mapping helpers for the K16
// front-panel scanner.
package k16_panel_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int NIBBLE_W  = 4;

    typedef logic [1:0] panel_state_t;

    localparam panel_state_t ST_IDLE   = 2'd0;
    localparam panel_state_t ST_SETTLE = 2'd1;
    localparam panel_state_t ST_SAMPLE = 2'd2;
    localparam panel_state_t ST_COMMIT = 2'd3;

    // Slots 0-3 come from lo_word, slots 4-7 from hi_word; nibble n of a word is slot n (+4).
    function automatic logic [NIBBLE_W-1:0] slot_nibble(input logic [15:0] lo_word,
                                                        input logic [15:0] hi_word,
                                                        input logic [2:0]  slot);
        logic [15:0] word;
        word = slot[2] ? hi_word : lo_word;
        return word[{slot[1:0], 2'b00} +: NIBBLE_W];
    endfunction

endpackage

// File: rtl/k16_panel_scanner_debouncer.sv
// Per-slot switch debouncer: commits a nibble after DEBOUNCE_SCANS identical samples
// and pulses changed for one cycle when the committed value moves.
module k16_nibble_debouncer
    import k16_panel_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_en,
    input  logic [NIBBLE_W-1:0] raw,
    output logic [NIBBLE_W-1:0] committed,
    output logic                changed
);

    localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_SCANS);

    logic [NIBBLE_W-1:0] last_q, last_d;
    logic [3:0]          count_q, count_d;
    logic [NIBBLE_W-1:0] committed_q, committed_d;
    logic                changed_q, changed_d;

    always_comb begin
        last_d      = last_q;
        count_d     = count_q;
        committed_d = committed_q;
        changed_d   = 1'b0;
        if (sample_en) begin
            if (raw == last_q) begin
                if (count_q < DEB_TARGET) count_d = count_q + 4'd1;
            end else begin
                last_d  = raw;
                count_d = 4'd1;
            end
            // raw equals last_d on both branches, so it is the candidate value.
            if (count_d == DEB_TARGET && raw != committed_q) begin
                committed_d = raw;
                changed_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q      <= '0;
            count_q     <= '0;
            committed_q <= '0;
            changed_q   <= 1'b0;
        end else begin
            last_q      <= last_d;
            count_q     <= count_d;
            committed_q <= committed_d;
            changed_q   <= changed_d;
        end
    end

    assign committed = committed_q;
    assign changed   = changed_q;

endmodule

// File: rtl/k16_panel_scanner.sv
// K16 front-panel scan controller: slot sequencing, tear-free LED snapshots and
// switch debouncing. Optional LED blanking during settle via `PANEL_BLANK_EN.
module k16_panel_scanner
    import k16_panel_pkg::*;
#(
    parameter int TICK_DIV       = 25000,
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr_leds,
    input  logic [15:0] data_leds,
    input  logic [3:0]  io_switches,
    output logic [2:0]  io_addr,
    output logic [3:0]  io_leds,
    output logic [15:0] addr_switches,
    output logic [15:0] ctrl_switches,
    output logic        sw_changed,
    output logic        frame_done,
    output logic [1:0]  dbg_state
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;
    panel_state_t      state_q, state_d;
    logic [2:0]        slot_q, slot_d;
    logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [2:0]        io_addr_q, io_addr_d;
    logic [3:0]        io_leds_q, io_leds_d;
    logic [3:0]        raw_sample_q, raw_sample_d;
    logic [15:0]       addr_snap_q, addr_snap_d;
    logic [15:0]       data_snap_q, data_snap_d;
    logic              snap_init_q, snap_init_d;
    logic              frame_done_q, frame_done_d;

    logic [NUM_SLOTS-1:0][NIBBLE_W-1:0] committed;
    logic [NUM_SLOTS-1:0]               changed;

    assign tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        settle_cnt_d = settle_cnt_q;
        io_addr_d    = io_addr_q;
        io_leds_d    = io_leds_q;
        raw_sample_d = raw_sample_q;
        addr_snap_d  = addr_snap_q;
        data_snap_d  = data_snap_q;
        snap_init_d  = 1'b1;
        frame_done_d = 1'b0;

        // First cycle out of reset takes a snapshot so frame 0 shows live LEDs.
        if (!snap_init_q) begin
            addr_snap_d = addr_leds;
            data_snap_d = data_leds;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    io_addr_d    = slot_q;
`ifdef PANEL_BLANK_EN
                    io_leds_d    = 4'h0;
`else
                    io_leds_d    = slot_nibble(addr_snap_q, data_snap_q, slot_q);
`endif
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end
            ST_SAMPLE: begin
                raw_sample_d = io_switches;
`ifdef PANEL_BLANK_EN
                io_leds_d    = slot_nibble(addr_snap_q, data_snap_q, io_addr_q);
`endif
                state_d      = ST_COMMIT;
            end
            ST_COMMIT: begin
                slot_d  = slot_q + 3'd1;
                state_d = ST_IDLE;
                if (slot_q == 3'd7) begin
                    frame_done_d = 1'b1;
                    addr_snap_d  = addr_leds;
                    data_snap_d  = data_leds;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q   <= '0;
            state_q      <= ST_IDLE;
            slot_q       <= '0;
            settle_cnt_q <= '0;
            io_addr_q    <= '0;
            io_leds_q    <= '0;
            raw_sample_q <= '0;
            addr_snap_q  <= '0;
            data_snap_q  <= '0;
            snap_init_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            state_q      <= state_d;
            slot_q       <= slot_d;
            settle_cnt_q <= settle_cnt_d;
            io_addr_q    <= io_addr_d;
            io_leds_q    <= io_leds_d;
            raw_sample_q <= raw_sample_d;
            addr_snap_q  <= addr_snap_d;
            data_snap_q  <= data_snap_d;
            snap_init_q  <= snap_init_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Only the slot being committed sees sample_en, so at most one nibble moves per COMMIT.
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_deb
        k16_nibble_debouncer #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
        ) u_deb (
            .clk      (clk),
            .reset    (reset),
            .sample_en((state_q == ST_COMMIT) && (slot_q == 3'(g))),
            .raw      (raw_sample_q),
            .committed(committed[g]),
            .changed  (changed[g])
        );
    end

    assign io_addr       = io_addr_q;
    assign io_leds       = io_leds_q;
    assign addr_switches = committed[3:0];
    assign ctrl_switches = committed[7:4];
    assign sw_changed    = |changed;
    assign frame_done    = frame_done_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_k16_panel_scanner.sv
// Directed bench for k16_panel_scanner with TICK_DIV=8, SETTLE_CYCLES=2, DEBOUNCE_SCANS=3.
// Honours `PANEL_BLANK_EN when the design is built with it.
module tb_k16_panel_scanner;
    import k16_panel_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr_leds;
    logic [15:0] data_leds;
    logic [3:0]  io_switches;
    logic [2:0]  io_addr;
    logic [3:0]  io_leds;
    logic [15:0] addr_switches;
    logic [15:0] ctrl_switches;
    logic        sw_changed;
    logic        frame_done;
    logic [1:0]  dbg_state;

    k16_panel_scanner #(
        .TICK_DIV      (8),
        .SETTLE_CYCLES (2),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .addr_leds    (addr_leds),
        .data_leds    (data_leds),
        .io_switches  (io_switches),
        .io_addr      (io_addr),
        .io_leds      (io_leds),
        .addr_switches(addr_switches),
        .ctrl_switches(ctrl_switches),
        .sw_changed   (sw_changed),
        .frame_done   (frame_done),
        .dbg_state    (dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_changed = 0;
    always @(negedge clk) if (sw_changed) n_changed <= n_changed + 1;

    // panel model: each slot presents its own switch nibble when addressed
    logic [3:0] sw_val [8];
    always_comb io_switches = sw_val[io_addr];

    int checks = 0;
    int failures = 0;

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_settle(output int n, output logic ok);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            n++;
            if (dbg_state == ST_SETTLE) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Follows one slot from address change to just after its COMMIT edge.
    task automatic run_slot(input int s, input logic [3:0] nib,
                            output logic chg, output logic fd, output int nw);
        logic ok;
        wait_settle(nw, ok);
        check($sformatf("settle_wait_s%0d", s), ok, 1);
        check($sformatf("io_addr_s%0d", s), io_addr, s);
`ifdef PANEL_BLANK_EN
        check($sformatf("leds_blank_first_s%0d", s), io_leds, 4'h0);
`else
        check($sformatf("leds_first_s%0d", s), io_leds, nib);
`endif
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("state_sample_s%0d", s), dbg_state, ST_SAMPLE);
`ifdef PANEL_BLANK_EN
        check($sformatf("leds_blank_last_s%0d", s), io_leds, 4'h0);
`else
        check($sformatf("leds_hold_s%0d", s), io_leds, nib);
`endif
        @(posedge clk); #1;
        check($sformatf("state_commit_s%0d", s), dbg_state, ST_COMMIT);
        check($sformatf("leds_commit_s%0d", s), io_leds, nib);
        @(posedge clk); #1;
        check($sformatf("state_idle_s%0d", s), dbg_state, ST_IDLE);
        chg = sw_changed;
        fd  = frame_done;
    endtask

    initial begin
        logic       chg, fd, ok;
        logic [3:0] exp_nib;
        int         nw, rel0, last_fd;

        reset     = 1'b1;
        addr_leds = 16'h4321;
        data_leds = 16'h8765;
        for (int i = 0; i < 8; i++) sw_val[i] = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_io_addr", io_addr, 0);
        check("rst_io_leds", io_leds, 0);
        check("rst_addr_sw", addr_switches, 0);
        check("rst_ctrl_sw", ctrl_switches, 0);
        check("rst_sw_changed", sw_changed, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_state", dbg_state, ST_IDLE);

        reset   = 1'b0;
        rel0    = cyc;
        last_fd = 0;
        for (int f = 1; f <= 6; f++) begin
            sw_val[0] = (f == 1) ? 4'h0 : (f == 3) ? 4'h5 : 4'hA;
            sw_val[5] = (f == 1) ? 4'h0 : 4'hA;
            for (int s = 0; s < 8; s++) begin
                exp_nib = (f == 6 && s >= 4) ? 4'(s + 6) : 4'(s + 1);
                run_slot(s, exp_nib, chg, fd, nw);
                if (f == 1 && s == 0) check("first_tick_latency", nw, 8);
                check($sformatf("sw_changed_f%0d_s%0d", f, s), chg,
                      (f == 4 && s == 5) || (f == 6 && s == 0));
                check($sformatf("frame_done_f%0d_s%0d", f, s), fd, s == 7);
                if (s == 0)
                    check($sformatf("addr_sw_f%0d", f), addr_switches,
                          (f == 6) ? 16'h000A : 16'h0000);
                if (s == 5)
                    check($sformatf("ctrl_sw_f%0d", f), ctrl_switches,
                          (f >= 4) ? 16'h00A0 : 16'h0000);
                if (s == 7) begin
                    if (f == 1) check("first_frame_done_cycle", cyc - rel0, 68);
                    else check($sformatf("frame_period_f%0d", f), cyc - last_fd, 64);
                    last_fd = cyc;
                end
                if (f == 5 && s == 2) data_leds = 16'hDCBA;
            end
        end
        check("sw_changed_pulse_count", n_changed, 2);

        // reset mid-scan: abandon slot 3 during its settle window
        for (int s = 0; s < 3; s++) run_slot(s, 4'(s + 1), chg, fd, nw);
        wait_settle(nw, ok);
        check("settle_wait_slot3", ok, 1);
        check("io_addr_before_reset", io_addr, 3);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_io_addr", io_addr, 0);
        check("midrst_io_leds", io_leds, 0);
        check("midrst_addr_sw", addr_switches, 0);
        check("midrst_ctrl_sw", ctrl_switches, 0);
        check("midrst_state", dbg_state, ST_IDLE);
        check("midrst_frame_done", frame_done, 0);
        reset = 1'b0;
        run_slot(0, 4'h1, chg, fd, nw);
        check("post_reset_tick_latency", nw, 8);
        check("post_reset_addr_sw", addr_switches, 0);
        check("post_reset_sw_changed", chg, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
